// File: rtl/spi_sclk_gen_pkg.sv
// Shared state encoding, configuration defaults and SPI mode constants
// for the runtime-configurable SPI serial-clock generator.
package spi_sclk_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int   DEF_HALF  = 0;
  localparam int   DEF_NBITS = 8;
  localparam logic DEF_CPOL  = 1'b0;
  localparam logic DEF_CPHA  = 1'b0;

  // Modes written as {cpol, cpha}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic logic nbits_legal(input int nbits, input int max_bits);
    return (nbits >= 1) && (nbits <= max_bits);
  endfunction

endpackage

// File: rtl/spi_sclk_gen_edge_timer.sv
// Half-period counter: counts 0..half while enabled and emits a one-cycle
// tick on the wrap cycle, which is where the next SCLK edge is registered.
module spi_edge_timer #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] half,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == half);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == half) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: configurable divisor, transfer length and
// CPOL/CPHA, with registered SCLK, sample/shift strobes, done and abort.
module spi_sclk_gen
  import spi_sclk_gen_pkg::*;
#(
  parameter  int DIV_W    = 8,
  parameter  int MAX_BITS = 32,
  localparam int BITS_W   = $clog2(MAX_BITS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_valid,
  input  logic [DIV_W-1:0]  i_cfg_half,
  input  logic [BITS_W-1:0] i_cfg_nbits,
  input  logic              i_cfg_cpol,
  input  logic              i_cfg_cpha,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_sclk,
  output logic              o_sample,
  output logic              o_shift,
  output logic [BITS_W-1:0] o_bit_idx,
  output logic              o_done,
  output logic              o_cfg_err
);

  state_t state, next_state;

  logic [DIV_W-1:0]  cfg_half;
  logic [BITS_W-1:0] cfg_nbits;
  logic              cfg_cpol, cfg_cpha;
  logic [1:0]        cfg_mode;
  logic [BITS_W:0]   edge_cnt, edge_cnt_d;

  logic              tick, last_edge, leading;
  logic              cfg_take, cfg_ok;
  logic              sample_on_lead, shift_on_lead;
  logic              sclk_d, sample_d, shift_d, done_d, err_d;
  logic [BITS_W-1:0] bit_idx_d;

  assign cfg_ok    = nbits_legal(int'(i_cfg_nbits), MAX_BITS);
  assign cfg_take  = (state == ST_IDLE) && i_cfg_valid;
  assign cfg_mode  = {cfg_cpol, cfg_cpha};
  assign leading   = ~edge_cnt[0];
  assign last_edge = (edge_cnt == (({1'b0, cfg_nbits} << 1) - (BITS_W + 1)'(1)));
  assign o_busy    = (state != ST_IDLE);

  assign sample_on_lead = (cfg_mode == SPI_MODE0) || (cfg_mode == SPI_MODE2);
  assign shift_on_lead  = (cfg_mode == SPI_MODE1) || (cfg_mode == SPI_MODE3);

  spi_edge_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .en      (state != ST_IDLE),
    .clr     ((state == ST_IDLE) || i_abort),
    .half    (cfg_half),
    .tick    (tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (i_start) next_state = ST_RUN;
      ST_RUN: begin
        if (i_abort) next_state = ST_IDLE;
        else if (tick && last_edge) next_state = ST_HOLD;
      end
      ST_HOLD: if (i_abort || tick) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // In IDLE the clock follows the config that will be in force next cycle,
  // so a same-cycle config+start already idles at the new polarity.
  always_comb begin
    sclk_d     = o_sclk;
    sample_d   = 1'b0;
    shift_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    bit_idx_d  = o_bit_idx;
    edge_cnt_d = edge_cnt;
    case (state)
      ST_IDLE: begin
        sclk_d = (cfg_take && cfg_ok) ? i_cfg_cpol : cfg_cpol;
        err_d  = cfg_take && !cfg_ok;
        if (i_start) begin
          bit_idx_d  = '0;
          edge_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          sclk_d = cfg_cpol;
        end else if (tick) begin
          sclk_d     = ~o_sclk;
          edge_cnt_d = edge_cnt + (BITS_W + 1)'(1);
          sample_d   = sample_on_lead ? leading : ~leading;
          shift_d    = shift_on_lead ? leading : (~leading && !last_edge);
          if (sample_d) bit_idx_d = o_bit_idx + BITS_W'(1);
        end
      end
      ST_HOLD: begin
        sclk_d = cfg_cpol;
        done_d = tick && !i_abort;
      end
      default: sclk_d = cfg_cpol;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_sclk    <= 1'b0;
      o_sample  <= 1'b0;
      o_shift   <= 1'b0;
      o_done    <= 1'b0;
      o_cfg_err <= 1'b0;
      o_bit_idx <= '0;
      edge_cnt  <= '0;
      cfg_half  <= DIV_W'(DEF_HALF);
      cfg_nbits <= BITS_W'(DEF_NBITS);
      cfg_cpol  <= DEF_CPOL;
      cfg_cpha  <= DEF_CPHA;
    end else begin
      o_sclk    <= sclk_d;
      o_sample  <= sample_d;
      o_shift   <= shift_d;
      o_done    <= done_d;
      o_cfg_err <= err_d;
      o_bit_idx <= bit_idx_d;
      edge_cnt  <= edge_cnt_d;
      if (cfg_take && cfg_ok) begin
        cfg_half  <= i_cfg_half;
        cfg_nbits <= i_cfg_nbits;
        cfg_cpol  <= i_cfg_cpol;
        cfg_cpha  <= i_cfg_cpha;
      end
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: directed scenarios plus random
// transfers, compared cycle by cycle against an arithmetic timing model.
module tb_spi_sclk_gen;

  localparam int DIV_W    = 8;
  localparam int MAX_BITS = 32;
  localparam int BITS_W   = $clog2(MAX_BITS + 1);

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_cfg_valid = 1'b0;
  logic [DIV_W-1:0]  i_cfg_half = '0;
  logic [BITS_W-1:0] i_cfg_nbits = '0;
  logic              i_cfg_cpol = 1'b0;
  logic              i_cfg_cpha = 1'b0;
  logic              i_start = 1'b0;
  logic              i_abort = 1'b0;
  logic              o_busy, o_sclk, o_sample, o_shift, o_done, o_cfg_err;
  logic [BITS_W-1:0] o_bit_idx;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Bench-side copy of the configuration the DUT should be holding.
  int m_half = 0, m_nbits = 8, m_cpol = 0, m_cpha = 0;

  spi_sclk_gen #(
    .DIV_W    (DIV_W),
    .MAX_BITS (MAX_BITS)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_half  (i_cfg_half),
    .i_cfg_nbits (i_cfg_nbits),
    .i_cfg_cpol  (i_cfg_cpol),
    .i_cfg_cpha  (i_cfg_cpha),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .o_busy      (o_busy),
    .o_sclk      (o_sclk),
    .o_sample    (o_sample),
    .o_shift     (o_shift),
    .o_bit_idx   (o_bit_idx),
    .o_done      (o_done),
    .o_cfg_err   (o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input int half, input int nbits,
                               input logic cpol, input logic cpha,
                               input logic start, input logic abort);
    i_cfg_valid = valid;
    i_cfg_half  = DIV_W'(half);
    i_cfg_nbits = BITS_W'(nbits);
    i_cfg_cpol  = cpol;
    i_cfg_cpha  = cpha;
    i_start     = start;
    i_abort     = abort;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 32'(o_busy), 0);
    checkOutput({tag, "_sclk"}, 32'(o_sclk), 0);
    checkOutput({tag, "_sample"}, 32'(o_sample), 0);
    checkOutput({tag, "_shift"}, 32'(o_shift), 0);
    checkOutput({tag, "_done"}, 32'(o_done), 0);
    checkOutput({tag, "_cfgerr"}, 32'(o_cfg_err), 0);
    checkOutput({tag, "_bitidx"}, 32'(o_bit_idx), 0);
  endtask

  task automatic loadConfig(input int h, input int n, input logic cpol, input logic cpha);
    logic legal;
    legal = (n >= 1) && (n <= MAX_BITS);
    @(negedge i_clk);
    applyStimulus(1'b1, h, n, cpol, cpha, 1'b0, 1'b0);
    if (legal) begin
      m_half = h; m_nbits = n; m_cpol = int'(cpol); m_cpha = int'(cpha);
    end
    @(negedge i_clk);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cfg_err_pulse", 32'(o_cfg_err), 32'(!legal));
    checkOutput("cfg_idle_sclk", 32'(o_sclk), 32'(m_cpol));
    @(negedge i_clk);
    checkOutput("cfg_err_clear", 32'(o_cfg_err), 0);
  endtask

  // Expected waveform for offset d after the start cycle: edge k becomes
  // visible at d = 1 + k*(half+1), done at d = 2*n*(half+1) + half + 2.
  task automatic runTransfer(input logic cfg_now, input int h, input int n,
                             input logic cpol, input logic cpha,
                             input int abort_at, input int noise_at);
    int   hh, nn, cp, ch, dd, edges, k, bidx, last_bidx;
    logic legal;
    @(negedge i_clk);
    checkOutput("pre_busy", 32'(o_busy), 0);
    legal = cfg_now && (n >= 1) && (n <= MAX_BITS);
    applyStimulus(cfg_now, h, n, cpol, cpha, 1'b1, 1'b0);
    if (legal) begin
      m_half = h; m_nbits = n; m_cpol = int'(cpol); m_cpha = int'(cpha);
    end
    hh = m_half; nn = m_nbits; cp = m_cpol; ch = m_cpha;
    dd = 2 * nn * (hh + 1) + hh + 2;
    last_bidx = 0;
    for (int d = 1; d <= dd; d++) begin
      @(negedge i_clk);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (abort_at > 0 && d == abort_at + 1) begin
        checkOutput("abort_busy", 32'(o_busy), 0);
        checkOutput("abort_sclk", 32'(o_sclk), 32'(cp));
        checkOutput("abort_sample", 32'(o_sample), 0);
        checkOutput("abort_shift", 32'(o_shift), 0);
        checkOutput("abort_done", 32'(o_done), 0);
        checkOutput("abort_bitidx", 32'(o_bit_idx), 32'(last_bidx));
        return;
      end
      edges = (d - 1) / (hh + 1);
      if (edges > 2 * nn) edges = 2 * nn;
      k = (d >= 2 && (d - 1) % (hh + 1) == 0 && (d - 1) / (hh + 1) <= 2 * nn) ? edges : 0;
      bidx = (ch != 0) ? edges / 2 : (edges + 1) / 2;
      checkOutput("busy", 32'(o_busy), 32'(d < dd));
      checkOutput("done", 32'(o_done), 32'(d == dd));
      checkOutput("sclk", 32'(o_sclk), 32'(cp ^ (edges % 2)));
      checkOutput("sample", 32'(o_sample),
                  32'(k != 0 && ((ch != 0) ? (k % 2 == 0) : (k % 2 == 1))));
      checkOutput("shift", 32'(o_shift),
                  32'(k != 0 && ((ch != 0) ? (k % 2 == 1) : (k % 2 == 0 && k != 2 * nn))));
      checkOutput("bit_idx", 32'(o_bit_idx), 32'(bidx));
      checkOutput("cfg_err", 32'(o_cfg_err), 32'(d == 1 && cfg_now && !legal));
      last_bidx = bidx;
      if (d == abort_at) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (d == noise_at)
        applyStimulus(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 40)),
                      1'($urandom), 1'($urandom), 1'b1, 1'b0);
    end
  endtask

  initial begin
    int h, n, dd, ab, nz;
    logic cp, ch;

    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge i_clk);
    checkResetState("reset");
    i_rst_n = 1'b1;

    $display("[TB] default mode 0 transfer");
    runTransfer(1'b0, 0, 0, 1'b0, 1'b0, -1, -1);

    $display("[TB] rejected configs keep nbits=8");
    loadConfig(4, 0, 1'b1, 1'b1);
    loadConfig(5, MAX_BITS + 1, 1'b1, 1'b0);
    runTransfer(1'b0, 0, 0, 1'b0, 1'b0, -1, -1);

    $display("[TB] mode 3, half=3, nbits=4");
    loadConfig(3, 4, 1'b1, 1'b1);
    runTransfer(1'b0, 0, 0, 1'b0, 1'b0, -1, -1);

    $display("[TB] config and start in the same cycle");
    runTransfer(1'b1, 1, 3, 1'b0, 1'b0, -1, -1);
    runTransfer(1'b1, 2, 0, 1'b1, 1'b1, -1, -1);

    $display("[TB] abort after edge 5, then a full transfer");
    loadConfig(0, 8, 1'b0, 1'b0);
    runTransfer(1'b0, 0, 0, 1'b0, 1'b0, 6, -1);
    runTransfer(1'b0, 0, 0, 1'b0, 1'b0, -1, -1);

    $display("[TB] start and config during RUN are ignored");
    runTransfer(1'b0, 0, 0, 1'b0, 1'b0, -1, 5);

    $display("[TB] reset in the middle of a transfer");
    loadConfig(2, 5, 1'b1, 1'b1);
    @(negedge i_clk);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) begin
      @(negedge i_clk);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checkResetState("midreset");
    i_rst_n = 1'b1;
    m_half = 0; m_nbits = 8; m_cpol = 0; m_cpha = 0;
    runTransfer(1'b0, 0, 0, 1'b0, 1'b0, -1, -1);

    $display("[TB] random transfers");
    for (int i = 0; i < 12; i++) begin
      h  = int'($urandom_range(0, 3));
      n  = int'($urandom_range(1, MAX_BITS));
      cp = 1'($urandom);
      ch = 1'($urandom);
      dd = 2 * n * (h + 1) + h + 2;
      ab = -1;
      nz = -1;
      case ($urandom_range(0, 2))
        0: ab = int'($urandom_range(2, dd - 1));
        1: nz = int'($urandom_range(2, dd - 1));
        default: ;
      endcase
      if (i % 3 == 0) begin
        runTransfer(1'b1, h, n, cp, ch, ab, nz);
      end else begin
        loadConfig(h, n, cp, ch);
        runTransfer(1'b0, 0, 0, 1'b0, 1'b0, ab, nz);
      end
    end

    repeat (2) @(negedge i_clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
